// File: rtl/analyzer_pkg.sv
// Shared definitions for the DAC stream analyzer: FSM state codes, result layout and the
// period saturation limit at the default widths.
package analyzer_pkg;

    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned DAC_W    = 14;

    typedef logic [1:0] state_t;

    localparam state_t ARM       = 2'd0;
    localparam state_t WAIT_RISE = 2'd1;
    localparam state_t MEASURE   = 2'd2;

    typedef struct packed {
        logic        [PERIOD_W-1:0] period;
        logic signed [DAC_W-1:0]    min_val;
        logic signed [DAC_W-1:0]    max_val;
    } result_t;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

endpackage

// File: rtl/analyzer_result_slot.sv
// One-entry valid/ready result register. A capture that arrives while the held result is
// still waiting is discarded and raises a sticky overrun flag.
module analyzer_result_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             ready,
    input  logic             clear_overrun,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             overrun
);

    logic valid_q;
    logic overrun_q;
    logic [WIDTH-1:0] data_q;
    logic load;
    logic drop;

    // A slot being drained in this cycle may be refilled in the same cycle.
    assign load = capture & (~valid_q | ready);
    assign drop = capture & valid_q & ~ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
        end else begin
            if (load) begin
                data_q  <= cap_data;
                valid_q <= 1'b1;
            end else if (ready) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign valid   = valid_q;
    assign data    = data_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/dac_stream_analyzer.sv
// AXI-Stream DAC sample sink measuring period, min and max between hysteretic rising crossings.
// Define DAC_STREAM_ANALYZER_P2P_EN to add the res_p2p (res_max - res_min) output.
module dac_stream_analyzer
    import analyzer_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 16,
    parameter int unsigned DAC_WIDTH        = DAC_W,
    parameter int unsigned PERIOD_WIDTH     = PERIOD_W,
    parameter int unsigned HYST             = 64
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                        s_axis_tready,
    input  logic                        enable,
    input  logic                        clear_overrun,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [PERIOD_WIDTH-1:0]     res_period,
    output logic signed [DAC_WIDTH-1:0] res_min,
    output logic signed [DAC_WIDTH-1:0] res_max,
`ifdef DAC_STREAM_ANALYZER_P2P_EN
    output logic [DAC_WIDTH:0]          res_p2p,
`endif
    output logic                        res_overrun
);

    localparam int unsigned CORE_WIDTH = PERIOD_WIDTH + 2 * DAC_WIDTH;
`ifdef DAC_STREAM_ANALYZER_P2P_EN
    localparam int unsigned RES_WIDTH = CORE_WIDTH + DAC_WIDTH + 1;
`else
    localparam int unsigned RES_WIDTH = CORE_WIDTH;
`endif

    localparam logic signed [DAC_WIDTH-1:0] HYST_HI = DAC_WIDTH'(HYST);
    localparam logic signed [DAC_WIDTH-1:0] HYST_LO = -HYST_HI;
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

    logic tready_q;
    logic accept;
    logic signed [DAC_WIDTH-1:0] sample;
    logic is_low;
    logic is_high;
    logic rise;
    logic capture;

    state_t state_q, state_d;
    logic armed_q, armed_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic signed [DAC_WIDTH-1:0] min_q, min_d;
    logic signed [DAC_WIDTH-1:0] max_q, max_d;

    logic [RES_WIDTH-1:0] res_in;
    logic [RES_WIDTH-1:0] res_out;

    generate
        if (AXIS_TDATA_WIDTH > DAC_WIDTH) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:DAC_WIDTH];
        end
    endgenerate

    // Ready comes out of a register so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end

    assign s_axis_tready = tready_q;
    assign accept  = s_axis_tvalid & tready_q;
    assign sample  = s_axis_tdata[DAC_WIDTH-1:0];
    assign is_low  = (sample <= HYST_LO);
    assign is_high = (sample >= HYST_HI);
    assign rise    = is_high & armed_q;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        capture = 1'b0;
        if (!enable) begin
            state_d = ARM;
            armed_d = 1'b0;
            cnt_d   = '0;
            min_d   = '0;
            max_d   = '0;
        end else if (accept) begin
            if (is_low) begin
                armed_d = 1'b1;
            end else if (rise) begin
                armed_d = 1'b0;
            end
            case (state_q)
                ARM: begin
                    if (is_low) begin
                        state_d = WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        min_d   = sample;
                        max_d   = sample;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // The result covers samples up to, not including, this crossing.
                        capture = 1'b1;
                        cnt_d   = CNT_ONE;
                        min_d   = sample;
                        max_d   = sample;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                        if (sample < min_q) begin
                            min_d = sample;
                        end
                        if (sample > max_q) begin
                            max_d = sample;
                        end
                    end
                end
                default: begin
                    state_d = ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ARM;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

`ifdef DAC_STREAM_ANALYZER_P2P_EN
    logic [DAC_WIDTH:0] p2p;
    assign p2p    = {max_q[DAC_WIDTH-1], max_q} - {min_q[DAC_WIDTH-1], min_q};
    assign res_in = {cnt_q, min_q, max_q, p2p};
`else
    assign res_in = {cnt_q, min_q, max_q};
`endif

    analyzer_result_slot #(
        .WIDTH(RES_WIDTH)
    ) u_slot (
        .clk          (clk),
        .aresetn      (aresetn),
        .capture      (capture),
        .cap_data     (res_in),
        .ready        (res_ready),
        .clear_overrun(clear_overrun),
        .valid        (res_valid),
        .data         (res_out),
        .overrun      (res_overrun)
    );

    assign res_period = res_out[RES_WIDTH-1 -: PERIOD_WIDTH];
    assign res_min    = res_out[RES_WIDTH-PERIOD_WIDTH-1 -: DAC_WIDTH];
    assign res_max    = res_out[RES_WIDTH-PERIOD_WIDTH-DAC_WIDTH-1 -: DAC_WIDTH];
`ifdef DAC_STREAM_ANALYZER_P2P_EN
    assign res_p2p    = res_out[DAC_WIDTH:0];
`endif

endmodule

// File: tb/tb_dac_stream_analyzer.sv
// Bench for dac_stream_analyzer: directed waveforms plus randomized gaps/backpressure, checked
// against a sample-window reference model. Define DAC_STREAM_ANALYZER_P2P_EN to cover res_p2p.
module tb_dac_stream_analyzer;
    import analyzer_pkg::*;

    localparam int HYST = 64;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic s_axis_tvalid = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic s_axis_tready;
    logic enable = 1'b0;
    logic clear_overrun = 1'b0;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [PERIOD_W-1:0] res_period;
    logic signed [DAC_W-1:0] res_min;
    logic signed [DAC_W-1:0] res_max;
    logic res_overrun;
`ifdef DAC_STREAM_ANALYZER_P2P_EN
    logic [DAC_W:0] res_p2p;
    logic [DAC_W:0] last_p2p = '0;
`endif

    always #5 clk = ~clk;

    dac_stream_analyzer #(
        .AXIS_TDATA_WIDTH(16),
        .DAC_WIDTH       (DAC_W),
        .PERIOD_WIDTH    (PERIOD_W),
        .HYST            (HYST)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tready(s_axis_tready),
        .enable       (enable),
        .clear_overrun(clear_overrun),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_period   (res_period),
        .res_min      (res_min),
        .res_max      (res_max),
`ifdef DAC_STREAM_ANALYZER_P2P_EN
        .res_p2p      (res_p2p),
`endif
        .res_overrun  (res_overrun)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: pending results, sticky overrun, and the samples since the last rise.
    result_t exp_q[$];
    bit exp_ovr = 1'b0;
    bit tready_m = 1'b0;
    bit armed_m = 1'b0;
    bit meas_m = 1'b0;
    int win_q[$];
    int dut_xfers = 0;
    result_t last_dut = '0;
    bit ready_n = 1'b1;
    bit en_n = 1'b1;
    bit rstn_n = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int tri_wave(input int p);
        int ph;
        ph = p % 1000;
        if (ph < 500) return -8190 + (16380 * ph) / 500;
        return 8190 - (16380 * (ph - 500)) / 500;
    endfunction

    task automatic clear_model();
        armed_m = 1'b0;
        meas_m  = 1'b0;
        win_q.delete();
    endtask

    task automatic push_result();
        result_t r;
        longint n;
        int mn;
        int mx;
        n  = win_q.size();
        mn = win_q[0];
        mx = win_q[0];
        foreach (win_q[i]) begin
            if (win_q[i] < mn) mn = win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
        end
        r.period  = (n > longint'(PERIOD_MAX)) ? PERIOD_MAX : PERIOD_W'(n);
        r.min_val = DAC_W'(mn);
        r.max_val = DAC_W'(mx);
        if (exp_q.size() != 0) exp_ovr = 1'b1;
        else exp_q.push_back(r);
    endtask

    task automatic process(input int s);
        bit low;
        bit rise;
        low  = (s <= -HYST);
        rise = (s >= HYST) && armed_m;
        if (rise) begin
            if (meas_m) push_result();
            win_q.delete();
            win_q.push_back(s);
            meas_m  = 1'b1;
            armed_m = 1'b0;
        end else begin
            if (meas_m) win_q.push_back(s);
            if (low) armed_m = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("s_axis_tready", s_axis_tready, tready_m);
        chk("res_valid", res_valid, exp_q.size() != 0);
        chk("res_overrun", res_overrun, exp_ovr);
        if (exp_q.size() != 0 && res_valid) begin
            chk("res_period", res_period, exp_q[0].period);
            chk("res_min", res_min, exp_q[0].min_val);
            chk("res_max", res_max, exp_q[0].max_val);
`ifdef DAC_STREAM_ANALYZER_P2P_EN
            chk("res_p2p", res_p2p, int'(exp_q[0].max_val) - int'(exp_q[0].min_val));
`endif
        end
    endtask

    // One clock: check outputs on the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input bit v, input int d, input bit clr = 1'b0);
        @(negedge clk);
        check_outputs();
        if (rstn_n && res_valid && ready_n) begin
            dut_xfers++;
            last_dut.period  = res_period;
            last_dut.min_val = res_min;
            last_dut.max_val = res_max;
`ifdef DAC_STREAM_ANALYZER_P2P_EN
            last_p2p = res_p2p;
`endif
        end
        aresetn       = rstn_n;
        s_axis_tvalid = v;
        s_axis_tdata  = 16'(d);
        res_ready     = ready_n;
        enable        = en_n;
        clear_overrun = clr;
        if (!rstn_n) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            clear_model();
        end else begin
            if (ready_n && exp_q.size() != 0) void'(exp_q.pop_front());
            if (clr) exp_ovr = 1'b0;
            if (!en_n) clear_model();
            else if (v && tready_m) process(d);
        end
        tready_m = rstn_n;
    endtask

    task automatic new_test();
        ready_n = 1'b1;
        en_n    = 1'b0;
        cycle(1'b0, 0);
        en_n    = 1'b1;
        dut_xfers = 0;
    endtask

    task automatic flush();
        repeat (3) cycle(1'b0, 0);
    endtask

    task automatic end_check(input string tag, input int per, input int mn, input int mx,
                             input int nmin);
        chk({tag, "_xfers"}, dut_xfers >= nmin, 1'b1);
        chk({tag, "_period"}, last_dut.period, per);
        chk({tag, "_min"}, last_dut.min_val, mn);
        chk({tag, "_max"}, last_dut.max_val, mx);
    endtask

    initial begin
        bit v;
        int p;
        int n;
        int half;
        int amp;

        // Reset state
        rstn_n = 1'b0;
        repeat (3) cycle(1'b0, 0);
        #1;
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_overrun", res_overrun, 1'b0);
        chk("rst_period", res_period, 0);
        chk("rst_min", res_min, 0);
        chk("rst_max", res_max, 0);
        rstn_n = 1'b1;
        repeat (2) cycle(1'b0, 0);

        // Triangle, period 1000, +/-8190
        new_test();
        for (int i = 0; i < 4000; i++) cycle(1'b1, tri_wave(i));
        flush();
        end_check("tri", 1000, -8190, 8190, 3);

        // Sawtooth stepping by 10; the falling jump re-arms
        new_test();
        for (int i = 0; i < 8195; i++) cycle(1'b1, -8191 + 10 * (i % 1639));
        flush();
        end_check("saw", 1639, -8191, 8189, 3);

        // Noise inside the hysteresis band never produces a result
        new_test();
        for (int i = 0; i < 2000; i++) cycle(1'b1, int'($urandom_range(100, 0)) - 50);
        flush();
        chk("noise_xfers", dut_xfers, 0);

        // Backpressure across three square periods: first result held, overrun flagged
        new_test();
        ready_n = 1'b0;
        for (int i = 0; i < 700; i++) cycle(1'b1, ((i / 100) % 2 == 1) ? 4000 : -4000);
        repeat (2) cycle(1'b0, 0);
        chk("ovr_valid", res_valid, 1'b1);
        chk("ovr_flag", res_overrun, 1'b1);
        chk("ovr_period", res_period, 200);
        chk("ovr_min", res_min, -4000);
        chk("ovr_max", res_max, 4000);
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0);
        chk("ovr_cleared", res_overrun, 1'b0);
        ready_n = 1'b1;
        cycle(1'b0, 0);
        cycle(1'b0, 0);
        chk("ovr_drop_valid", res_valid, 1'b0);
        chk("ovr_xfers", dut_xfers, 1);
        chk("ovr_xfer_period", last_dut.period, 200);

        // Reset in the middle of a triangle period
        new_test();
        for (int i = 0; i < 500; i++) cycle(1'b1, tri_wave(i));
        rstn_n = 1'b0;
        cycle(1'b1, tri_wave(500));
        cycle(1'b1, tri_wave(501));
        rstn_n = 1'b1;
        dut_xfers = 0;
        for (int i = 502; i < 3500; i++) cycle(1'b1, tri_wave(i));
        flush();
        end_check("rst_mid", 1000, -8190, 8190, 1);

        // Random tvalid gaps: only accepted samples advance the waveform and the count
        new_test();
        p = 0;
        n = 0;
        while (p < 4000 && n < 20000) begin
            v = 1'($urandom_range(1, 0));
            cycle(v, v ? tri_wave(p) : int'($urandom_range(16383, 0)));
            if (v) p++;
            n++;
        end
        flush();
        end_check("gap", 1000, -8190, 8190, 3);
`ifdef DAC_STREAM_ANALYZER_P2P_EN
        chk("gap_p2p", last_p2p, 16380);
`endif

        // Random square waves with random backpressure, clears and enable drops
        new_test();
        half = int'($urandom_range(80, 20));
        amp  = int'($urandom_range(8000, 100));
        for (int i = 0; i < 3000; i++) begin
            ready_n = ($urandom_range(3, 0) != 0);
            en_n    = ($urandom_range(499, 0) != 0);
            v       = ($urandom_range(3, 0) != 0);
            cycle(v, ((i / half) % 2 == 1) ? amp : -amp, $urandom_range(15, 0) == 0);
        end
        ready_n = 1'b1;
        en_n    = 1'b1;
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_stream_analyzer.md
Name: dac_stream_analyzer

Overview:
- AXI-Stream sink for the DAC sample stream produced by the signal generator. Consumes the same s_axis_tvalid/s_axis_tdata interface the generator drives.
- Measures each waveform period using hysteretic rising zero crossings, and per-period min and max sample values.
- Hands one result per period to the control/readback side over a valid/ready port. Sits between the generator output and the DAC, or on a loopback tap, for self-test.

Parameters:
- AXIS_TDATA_WIDTH, 16, stream data width.
- DAC_WIDTH, 14, sample width; tdata[DAC_WIDTH-1:0] is interpreted as signed two's complement, upper bits ignored.
- PERIOD_WIDTH, 32, period counter width.
- HYST, 64, crossing hysteresis threshold (positive, < 2^(DAC_WIDTH-1)).

Ports:
- clk  in  1  clock
- aresetn  in  1  reset: one clock; reset is asynchronous and active-low
- s_axis_tvalid  in  1  sample valid
- s_axis_tdata  in  AXIS_TDATA_WIDTH  sample
- s_axis_tready  out  1  tied 1 out of reset; the producer cannot stall
- enable  in  1  measurement enable
- clear_overrun  in  1  single-cycle pulse, clears res_overrun
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_period  out  PERIOD_WIDTH  samples per period
- res_min  out  DAC_WIDTH  signed minimum sample in the period
- res_max  out  DAC_WIDTH  signed maximum sample in the period
- res_overrun  out  1  sticky flag: a result was dropped

Behaviour:
- Reset values:
  - All outputs 0, except s_axis_tready, which is 0 during reset and 1 after it.
  - State = ARM; counters and internal min/max cleared.
- Sample accepted = s_axis_tvalid & s_axis_tready; all logic advances only on accepted samples.
- Crossing rules:
  - low = sample <= -HYST; high = sample >= HYST.
  - rise = high while armed; armed is set by low and cleared by rise.
- States:
  - ARM: wait for low → WAIT_RISE.
  - WAIT_RISE: on rise → MEASURE; set cnt = 1, min = max = sample.
  - MEASURE, on a non-rise sample: cnt = cnt + 1 (saturating at 2^PERIOD_WIDTH-1, no wrap); update min/max with signed compares. A low sample re-arms.
  - MEASURE, on rise: capture {cnt, min, max} from before this sample as the result; restart with cnt = 1, min = max = current sample; clear armed.
- enable low:
  - State → ARM next cycle, armed cleared, cnt/min/max cleared.
  - A pending result stays valid; res_overrun is unaffected.
  - enable rising starts from ARM.
- Result handshake:
  - res_valid rises the cycle after the rise sample is accepted.
  - Outputs are held stable while res_valid & ~res_ready.
  - Transfer occurs on res_valid & res_ready; res_valid drops the next cycle unless a new capture occurs in the same cycle.
  - Capture with a slot that is empty or being consumed in the same cycle: load the new result, res_valid = 1, no overrun.
  - Capture while res_valid & ~res_ready: the new result is dropped, the held result is unchanged, res_overrun ← 1.
  - clear_overrun in the same cycle as a new overrun: the overrun wins (flag stays 1).
- Reset mid-measurement: immediate return to reset values; no partial result is emitted.
- An accepted sample with s_axis_tvalid low does nothing; gaps in tvalid do not count as samples.

Optional Feature:
- DAC_STREAM_ANALYZER_P2P_EN
- Defined: adds output res_p2p, DAC_WIDTH+1 bits, unsigned = res_max - res_min. It is registered in the same cycle as the result (no added latency) and follows the same hold rules.
- Undefined: no port and no subtractor logic.

Decomposition:
- Shared package (analyzer_pkg):
  - state enum {ARM, WAIT_RISE, MEASURE}
  - result struct {period, min, max}
  - saturation constant PERIOD_MAX
- Natural sub-module: analyzer_result_slot — one-entry valid/ready holding register with overrun detection. The main block holds the crossing FSM and accumulators.

Test Plan:
- Triangle of period 1000 samples, ±8190, HYST = 64, res_ready = 1 → second and later results: res_period = 1000, res_min = -8190, res_max = 8190; res_overrun = 0.
- Sawtooth from -8191 to +8190 stepping by 10 → falling jump re-arms; res_period = 1639 each period; res_min = -8191, res_max = 8189.
- Noise of ±50 around 0 (inside HYST) → no result ever; state stays ARM/WAIT_RISE.
- res_ready = 0 across 3 periods of a 200-sample square wave at ±4000 → first result held stable and unchanged, res_overrun = 1. clear_overrun pulse → 0. res_ready = 1 → one transfer, res_valid drops the next cycle.
- Assert aresetn = 0 at sample 500 of the 1000-sample triangle, release, continue → no result until a full low→rise→rise sequence; the first result is correct (1000, -8190, 8190).
- s_axis_tvalid toggled 50% on the 1000-sample triangle → res_period still 1000 (counts accepted samples only). With the macro defined → res_p2p = 16380.
